// File: rtl/wb_slot_scheduler_if.sv
// Pipe 1 issue/writeback bundle for wb_slot_scheduler.
// WB_SCHED_STATS_EN adds the alu_conflict_cnt statistic.
interface wb_slot_scheduler_if;
  logic alu_req;
  logic imul_req;
  logic flush;
  logic alu_grant;
  logic imul_grant;
  logic wb_valid;
  logic wb_sel;
  logic busy;
`ifdef WB_SCHED_STATS_EN
  logic [31:0] alu_conflict_cnt;

  modport master (
    output alu_req, imul_req, flush,
    input  alu_grant, imul_grant, wb_valid, wb_sel, busy, alu_conflict_cnt
  );
  modport slave (
    input  alu_req, imul_req, flush,
    output alu_grant, imul_grant, wb_valid, wb_sel, busy, alu_conflict_cnt
  );
`else
  modport master (
    output alu_req, imul_req, flush,
    input  alu_grant, imul_grant, wb_valid, wb_sel, busy
  );
  modport slave (
    input  alu_req, imul_req, flush,
    output alu_grant, imul_grant, wb_valid, wb_sel, busy
  );
`endif
endinterface

// File: rtl/wb_slot_scheduler.sv
// Pipe 1 writeback-slot scheduler: arbitrates ALU (1-cycle) vs IMUL (LAT-cycle) issue so that
// results never collide on the shared result bus. WB_SCHED_STATS_EN adds alu_conflict_cnt.
module wb_slot_scheduler #(
  parameter int unsigned LAT        = 3,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clock,
  input logic               reset,
  wb_slot_scheduler_if.slave bus
);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  // Slot k holds the writeback due k cycles from now; rs marks IMUL as source.
  logic [LAT:1] rv_q, rv_d, rs_q, rs_d;
  logic [LAT:1] rv_sh, rs_sh;
  logic [3:0]   sc_q, sc_d;
  logic         rr_q, rr_d;
  logic         alu_elig, imul_elig, alu_gnt, imul_gnt;

  always_comb begin
    rv_sh     = {1'b0, rv_q[LAT:2]};
    rs_sh     = {1'b0, rs_q[LAT:2]};
    alu_elig  = bus.alu_req && !rv_sh[1];
    imul_elig = bus.imul_req && (sc_q < StarveMax);
    alu_gnt   = 1'b0;
    imul_gnt  = 1'b0;
    rr_d      = rr_q;
    if (!reset && !bus.flush) begin
      if (alu_elig && imul_elig) begin
        alu_gnt  = !rr_q;
        imul_gnt = rr_q;
        rr_d     = !rr_q;
      end else begin
        alu_gnt  = alu_elig;
        imul_gnt = imul_elig;
      end
    end

    rv_d = rv_sh;
    rs_d = rs_sh;
    if (alu_gnt) begin
      rv_d[1] = 1'b1;
      rs_d[1] = 1'b0;
    end
    if (imul_gnt) begin
      rv_d[LAT] = 1'b1;
      rs_d[LAT] = 1'b1;
    end

    // Starvation counter only advances while the ALU is structurally blocked.
    if (!bus.alu_req || alu_gnt) begin
      sc_d = 4'd0;
    end else if (!alu_elig && sc_q != 4'hF) begin
      sc_d = sc_q + 4'd1;
    end else begin
      sc_d = sc_q;
    end

    if (bus.flush) begin
      rv_d = '0;
      rs_d = '0;
      sc_d = 4'd0;
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rv_q <= '0;
      rs_q <= '0;
      sc_q <= 4'd0;
      rr_q <= 1'b0;
    end else begin
      rv_q <= rv_d;
      rs_q <= rs_d;
      sc_q <= sc_d;
      rr_q <= rr_d;
    end
  end

  // Outputs are forced low during reset, including the first cycle before state clears.
  assign bus.alu_grant  = alu_gnt;
  assign bus.imul_grant = imul_gnt;
  assign bus.wb_valid   = rv_q[1] && !reset;
  assign bus.wb_sel     = rs_q[1] && !reset;
  assign bus.busy       = (|rv_q) && !reset;

`ifdef WB_SCHED_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.alu_req && !alu_gnt && !bus.flush) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.alu_conflict_cnt = cnt_q;
`endif

`ifndef SYNTHESIS
  a_one_grant: assert property (@(posedge clock) disable iff (reset) !(alu_gnt && imul_gnt));
  a_no_double_wb: assert property (@(posedge clock) disable iff (reset)
    !(alu_gnt && rv_sh[1]) && !(imul_gnt && rv_sh[LAT]));
`endif
endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Randomized bench for wb_slot_scheduler against an absolute-time writeback-calendar model.
// Honours WB_SCHED_STATS_EN when the design is built with it.
module tb_wb_slot_scheduler;
  localparam int LAT        = 3;
  localparam int STARVE_MAX = 4;
  localparam int MAXC       = 4096;

  logic clock;
  logic reset;
  wb_slot_scheduler_if bus_if ();

  wb_slot_scheduler #(
    .LAT        (LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // due[c]: -1 = nothing, 0 = ALU result, 1 = IMUL result on the bus in absolute cycle c.
  int due [0:MAXC+15];
  int t = 0;
  int m_rr = 0;
  int m_sc = 0;
  int unsigned m_cnt = 0;
  logic o_ag, o_mg, o_wv, o_ws, o_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge, compare against model, advance model.
  task automatic step(input logic a, input logic m, input logic f, input logic r);
    logic e_ag, e_mg, e_wv, e_ws, e_busy, alu_ok, imul_ok;
    reset           = r;
    bus_if.alu_req  = a;
    bus_if.imul_req = m;
    bus_if.flush    = f;
    @(negedge clock);
    o_ag   = bus_if.alu_grant;
    o_mg   = bus_if.imul_grant;
    o_wv   = bus_if.wb_valid;
    o_ws   = bus_if.wb_sel;
    o_busy = bus_if.busy;

    e_ag = 0; e_mg = 0; e_wv = 0; e_ws = 0; e_busy = 0;
    if (!r) begin
      e_wv = (due[t] != -1);
      e_ws = (due[t] == 1);
      for (int k = 0; k < LAT; k++) if (due[t+k] != -1) e_busy = 1;
      if (!f) begin
        alu_ok  = a && (due[t+1] == -1);
        imul_ok = m && (m_sc < STARVE_MAX);
        if (alu_ok && imul_ok) begin
          e_ag = (m_rr == 0);
          e_mg = (m_rr == 1);
        end else begin
          e_ag = alu_ok;
          e_mg = imul_ok;
        end
      end
    end
    check_eq("alu_grant", 32'(o_ag), 32'(e_ag));
    check_eq("imul_grant", 32'(o_mg), 32'(e_mg));
    check_eq("wb_valid", 32'(o_wv), 32'(e_wv));
    if (e_wv) check_eq("wb_sel", 32'(o_ws), 32'(e_ws));
    check_eq("busy", 32'(o_busy), 32'(e_busy));
`ifdef WB_SCHED_STATS_EN
    if (!r) check_eq("conflict_cnt", bus_if.alu_conflict_cnt, m_cnt);
`endif

    if (r || f) begin
      for (int k = (r ? 0 : 1); k <= LAT + 1; k++) due[t+k] = -1;
      m_rr = 0;
      m_sc = 0;
      if (r) m_cnt = 0;
    end else begin
      if (e_ag) begin
        check_eq("double_wb", 32'(due[t+1] != -1), 32'd0);
        due[t+1] = 0;
      end
      if (e_mg) begin
        check_eq("double_wb", 32'(due[t+LAT] != -1), 32'd0);
        due[t+LAT] = 1;
      end
      if (alu_ok && imul_ok) m_rr = 1 - m_rr;
      if (!a || e_ag) m_sc = 0;
      else if (!alu_ok && m_sc < 15) m_sc++;
      if (a && !e_ag) m_cnt++;
    end
    @(posedge clock);
    #1;
    t++;
  endtask

  initial begin
    for (int i = 0; i <= MAXC + 15; i++) due[i] = -1;
    reset = 1'b1;
    bus_if.alu_req  = 1'b0;
    bus_if.imul_req = 1'b0;
    bus_if.flush    = 1'b0;
    @(posedge clock);
    #1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Lone IMUL: grant at 0, result at LAT, busy across 1..LAT.
    step(0, 1, 0, 0); check_eq("imul_pulse_grant", 32'(o_mg), 32'd1);
    check_eq("imul_pulse_busy0", 32'(o_busy), 32'd0);
    step(0, 0, 0, 0); check_eq("imul_pulse_busy1", 32'(o_busy), 32'd1);
    step(0, 0, 0, 0); check_eq("imul_pulse_busy2", 32'(o_busy), 32'd1);
    step(0, 0, 0, 0); check_eq("imul_pulse_wb", 32'({o_wv, o_ws, o_busy}), 32'b111);
    step(0, 0, 0, 0); check_eq("imul_pulse_idle", 32'({o_wv, o_busy}), 32'b00);

    // ALU blocked by the IMUL due slot, then granted one cycle later.
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); check_eq("alu_blocked", 32'(o_ag), 32'd0);
    step(1, 0, 0, 0); check_eq("alu_after_block", 32'({o_ag, o_wv, o_ws}), 32'b111);
`ifdef WB_SCHED_STATS_EN
    check_eq("conflict_cnt_one", bus_if.alu_conflict_cnt, 32'd1);
`endif
    step(1, 0, 0, 0); check_eq("alu_wb", 32'({o_wv, o_ws}), 32'b10);
    step(0, 0, 0, 1);
`ifdef WB_SCHED_STATS_EN
    step(0, 0, 0, 0); check_eq("conflict_cnt_reset", bus_if.alu_conflict_cnt, 32'd0);
`endif

    // Flush with two IMULs in flight.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 0); check_eq("flush_grants", 32'({o_ag, o_mg}), 32'b00);
    step(0, 0, 0, 0); check_eq("flush_busy", 32'({o_wv, o_busy}), 32'b00);
    for (int i = 0; i < LAT + 1; i++) begin
      step(0, 0, 0, 0); check_eq("flush_no_wb", 32'(o_wv), 32'd0);
    end

    // Reset while results pending discards them.
    step(0, 1, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < LAT + 1; i++) begin
      step(0, 0, 0, 0); check_eq("reset_no_wb", 32'(o_wv), 32'd0);
    end

    // Both requests held continuously: alternation plus starvation relief.
    for (int i = 0; i < 120; i++) step(1, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 48) == 0,
           ($urandom % 300) == 0);
    end
    step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
